// File: rtl/rom_stream_sink.sv
// Packs the byte-serial ROM load stream into little-endian 16-bit words and
// writes them sequentially to SDRAM through the wr/wait port, via a small word FIFO.
module rom_stream_sink #(
    parameter logic [22:0] BASE_ADDR  = 23'h000000,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic        wclk,
    input  logic        reset,
    input  logic        rom_loading,
    input  logic [7:0]  rom_do,
    input  logic        rom_do_valid,
    output logic [22:0] mem_addr,
    output logic [15:0] mem_din,
    output logic [1:0]  mem_ds,
    output logic        mem_wr,
    input  logic        mem_wait,
    output logic        busy,
    output logic        done,
    output logic [23:0] byte_count,
    output logic        overflow
);

    localparam int unsigned ADDR_W = 23;
    localparam int unsigned IDX_W  = 22;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned DS_W   = 2;
    localparam int unsigned CNT_W  = 24;
    localparam int unsigned ENT_W  = IDX_W + DS_W + DATA_W;
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned FC_W   = PTR_W + 1;

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } state_t;

    state_t state;
    state_t state_nxt;

    logic               load_q;
    logic               start_c;
    logic               stop_c;
    logic               accept_c;
    logic               odd_c;

    logic               pend_v;
    logic [7:0]         pend_byte;
    logic [IDX_W-1:0]   wr_idx;

    logic               push_c;
    logic [ENT_W-1:0]   push_ent_c;
    logic               push_ok_c;
    logic               drop_c;
    logic               pop_c;
    logic               issue_c;
    logic               wr_nxt_c;
    logic               drained_c;

    logic [ENT_W-1:0]   fifo_mem [FIFO_DEPTH];
    logic [FC_W-1:0]    wptr;
    logic [FC_W-1:0]    rptr;
    logic [FC_W-1:0]    fifo_cnt;
    logic               fifo_empty;
    logic               fifo_full;
    logic [ENT_W-1:0]   head_ent;
    logic [IDX_W-1:0]   head_idx;
    logic [DS_W-1:0]    head_ds;
    logic [DATA_W-1:0]  head_data;

    // Load framing: edges of the registered rom_loading level.
    assign start_c  = rom_loading & ~load_q;
    assign stop_c   = ~rom_loading & load_q;
    assign accept_c = rom_do_valid & rom_loading;
    // The start cycle counts from zero, so a byte there is always the even one.
    assign odd_c    = start_c ? 1'b0 : byte_count[0];

    always_ff @(posedge wclk or posedge reset) begin
        if (reset) begin
            load_q <= 1'b0;
        end else begin
            load_q <= rom_loading;
        end
    end

    // Word assembly: odd bytes complete a word, a trailing even byte is flushed at end.
    always_comb begin
        push_c     = 1'b0;
        push_ent_c = '0;
        if (accept_c && odd_c) begin
            push_c     = 1'b1;
            push_ent_c = {wr_idx, 2'b11, rom_do, pend_byte};
        end else if (stop_c && pend_v) begin
            push_c     = 1'b1;
            push_ent_c = {wr_idx, 2'b01, 8'h00, pend_byte};
        end
    end

    always_ff @(posedge wclk or posedge reset) begin
        if (reset) begin
            pend_v    <= 1'b0;
            pend_byte <= 8'h00;
            wr_idx    <= '0;
        end else if (start_c) begin
            pend_v    <= accept_c;
            pend_byte <= accept_c ? rom_do : 8'h00;
            wr_idx    <= '0;
        end else begin
            if (accept_c && !odd_c) begin
                pend_v    <= 1'b1;
                pend_byte <= rom_do;
            end else if (accept_c || stop_c) begin
                pend_v    <= 1'b0;
            end
            // Dropped words still consume an index so later addresses stay correct.
            if (push_c) begin
                wr_idx <= wr_idx + IDX_W'(1);
            end
        end
    end

    // Word FIFO: a pop in the same cycle frees the slot for a push when full.
    assign fifo_cnt   = wptr - rptr;
    assign fifo_empty = (wptr == rptr);
    assign fifo_full  = (fifo_cnt == FC_W'(FIFO_DEPTH));
    assign push_ok_c  = push_c && (!fifo_full || pop_c);
    assign drop_c     = push_c && fifo_full && !pop_c;
    assign head_ent   = fifo_mem[rptr[PTR_W-1:0]];
    assign head_idx   = head_ent[ENT_W-1 -: IDX_W];
    assign head_ds    = head_ent[DATA_W +: DS_W];
    assign head_data  = head_ent[DATA_W-1:0];

    always_ff @(posedge wclk) begin
        if (push_ok_c) begin
            fifo_mem[wptr[PTR_W-1:0]] <= push_ent_c;
        end
    end

    always_ff @(posedge wclk or posedge reset) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
        end else if (start_c) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push_ok_c) begin
                wptr <= wptr + FC_W'(1);
            end
            if (pop_c) begin
                rptr <= rptr + FC_W'(1);
            end
        end
    end

    // Write FSM: state register.
    always_ff @(posedge wclk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Write FSM: next state; a start aborts any write in flight.
    always_comb begin
        state_nxt = state;
        if (start_c) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE: if (!fifo_empty) state_nxt = S_WAIT;
                S_WAIT: if (!mem_wait) state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // Write FSM: outputs. The head moves into the write registers when issued,
    // which then hold it unchanged across wait retries.
    always_comb begin
        issue_c  = 1'b0;
        pop_c    = 1'b0;
        wr_nxt_c = 1'b0;
        if (!start_c) begin
            case (state)
                S_IDLE: begin
                    if (!fifo_empty) begin
                        issue_c  = 1'b1;
                        pop_c    = 1'b1;
                        wr_nxt_c = 1'b1;
                    end
                end
                S_WAIT: wr_nxt_c = mem_wait;
                default: wr_nxt_c = 1'b0;
            endcase
        end
    end

    always_ff @(posedge wclk or posedge reset) begin
        if (reset) begin
            mem_wr   <= 1'b0;
            mem_addr <= BASE_ADDR;
            mem_din  <= '0;
            mem_ds   <= '0;
        end else begin
            mem_wr <= wr_nxt_c;
            if (issue_c) begin
                mem_addr <= ADDR_W'(BASE_ADDR + {head_idx, 1'b0});
                mem_din  <= head_data;
                mem_ds   <= head_ds;
            end
        end
    end

    // Completion once the source has stopped and every word is accepted.
    assign drained_c = !rom_loading && !load_q && !pend_v && fifo_empty && (state == S_IDLE);

    always_ff @(posedge wclk or posedge reset) begin
        if (reset) begin
            busy       <= 1'b0;
            done       <= 1'b0;
            byte_count <= '0;
            overflow   <= 1'b0;
        end else if (start_c) begin
            busy       <= 1'b1;
            done       <= 1'b0;
            overflow   <= 1'b0;
            byte_count <= accept_c ? CNT_W'(1) : '0;
        end else begin
            if (accept_c) begin
                byte_count <= byte_count + CNT_W'(1);
            end
            if (drop_c) begin
                overflow <= 1'b1;
            end
            if (busy && drained_c) begin
                busy <= 1'b0;
                done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rom_stream_sink.sv
// Directed bench for rom_stream_sink: instance 0 at base 0 / depth 8,
// instance 1 at base 7FFFFC / depth 4 for overflow and address wrap.
module tb_rom_stream_sink;

    logic        wclk;
    logic        reset;
    logic        rom_loading  [2];
    logic [7:0]  rom_do       [2];
    logic        rom_do_valid [2];
    logic        mem_wait     [2];
    logic [22:0] mem_addr     [2];
    logic [15:0] mem_din      [2];
    logic [1:0]  mem_ds       [2];
    logic        mem_wr       [2];
    logic        busy         [2];
    logic        done         [2];
    logic [23:0] byte_count   [2];
    logic        overflow     [2];

    logic [40:0] log0 [$];
    logic [40:0] log1 [$];

    int n_chk;
    int n_bad;

    rom_stream_sink #(.BASE_ADDR(23'h000000), .FIFO_DEPTH(8)) u_dut0 (
        .wclk(wclk), .reset(reset),
        .rom_loading(rom_loading[0]), .rom_do(rom_do[0]), .rom_do_valid(rom_do_valid[0]),
        .mem_addr(mem_addr[0]), .mem_din(mem_din[0]), .mem_ds(mem_ds[0]),
        .mem_wr(mem_wr[0]), .mem_wait(mem_wait[0]),
        .busy(busy[0]), .done(done[0]), .byte_count(byte_count[0]), .overflow(overflow[0])
    );

    rom_stream_sink #(.BASE_ADDR(23'h7FFFFC), .FIFO_DEPTH(4)) u_dut1 (
        .wclk(wclk), .reset(reset),
        .rom_loading(rom_loading[1]), .rom_do(rom_do[1]), .rom_do_valid(rom_do_valid[1]),
        .mem_addr(mem_addr[1]), .mem_din(mem_din[1]), .mem_ds(mem_ds[1]),
        .mem_wr(mem_wr[1]), .mem_wait(mem_wait[1]),
        .busy(busy[1]), .done(done[1]), .byte_count(byte_count[1]), .overflow(overflow[1])
    );

    initial begin
        wclk = 1'b0;
        forever #5 wclk = ~wclk;
    end

    // Memory side: a write lands in a cycle with mem_wr high and mem_wait low.
    always @(negedge wclk) begin
        if (mem_wr[0] && !mem_wait[0]) log0.push_back({mem_addr[0], mem_din[0], mem_ds[0]});
        if (mem_wr[1] && !mem_wait[1]) log1.push_back({mem_addr[1], mem_din[1], mem_ds[1]});
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge wclk);
        #1;
    endtask

    task automatic send_byte(input int n, input logic [7:0] b);
        rom_do[n]       = b;
        rom_do_valid[n] = 1'b1;
        tick();
        rom_do_valid[n] = 1'b0;
    endtask

    task automatic end_load(input int n);
        rom_loading[n] = 1'b0;
        tick();
    endtask

    task automatic wait_done(input int n, input string tag);
        for (int i = 0; i < 100; i++) begin
            if (done[n]) break;
            tick();
        end
        chk(tag, 64'(done[n]), 64'd1);
    endtask

    task automatic check_wr(input int n, input int i, input logic [22:0] a,
                            input logic [15:0] d, input logic [1:0] s);
        logic [40:0] got;
        got = '1;
        if (n == 0 && i < log0.size()) got = log0[i];
        if (n == 1 && i < log1.size()) got = log1[i];
        chk($sformatf("wr%0d_%0d", n, i), 64'(got), 64'({a, d, s}));
    endtask

    task automatic check_log_size(input int n, input int exp, input string tag);
        chk(tag, 64'((n == 0) ? log0.size() : log1.size()), 64'(exp));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        n_chk = 0;
        n_bad = 0;
        reset = 1'b1;
        for (int n = 0; n < 2; n++) begin
            rom_loading[n]  = 1'b0;
            rom_do[n]       = 8'h00;
            rom_do_valid[n] = 1'b0;
            mem_wait[n]     = 1'b0;
        end
        #23;
        chk("rst_addr0", 64'(mem_addr[0]), 64'h000000);
        chk("rst_addr1", 64'(mem_addr[1]), 64'h7FFFFC);
        chk("rst_din", 64'(mem_din[0]), 64'h0);
        chk("rst_ds", 64'(mem_ds[0]), 64'h0);
        chk("rst_wr", 64'(mem_wr[0]), 64'h0);
        chk("rst_busy", 64'(busy[0]), 64'h0);
        chk("rst_done", 64'(done[0]), 64'h0);
        chk("rst_cnt", 64'(byte_count[0]), 64'h0);
        chk("rst_ovf", 64'(overflow[0]), 64'h0);
        tick();
        reset = 1'b0;
        tick();

        // Happy path: 8 bytes back to back, no wait.
        log0.delete();
        rom_loading[0] = 1'b1;
        for (int i = 1; i <= 8; i++) send_byte(0, 8'(i));
        chk("happy_busy", 64'(busy[0]), 64'h1);
        end_load(0);
        wait_done(0, "happy_done");
        check_log_size(0, 4, "happy_nwr");
        check_wr(0, 0, 23'h0, 16'h0201, 2'b11);
        check_wr(0, 1, 23'h2, 16'h0403, 2'b11);
        check_wr(0, 2, 23'h4, 16'h0605, 2'b11);
        check_wr(0, 3, 23'h6, 16'h0807, 2'b11);
        chk("happy_cnt", 64'(byte_count[0]), 64'd8);
        chk("happy_ovf", 64'(overflow[0]), 64'h0);
        chk("happy_idle", 64'(busy[0]), 64'h0);

        // Odd length: trailing byte goes out with ds=01, done waits for it.
        log0.delete();
        rom_loading[0] = 1'b1;
        send_byte(0, 8'hAA);
        send_byte(0, 8'hBB);
        send_byte(0, 8'hCC);
        end_load(0);
        for (int i = 0; i < 50; i++) begin
            if (log0.size() >= 2) break;
            tick();
        end
        chk("odd_done_early", 64'(done[0]), 64'h0);
        chk("odd_busy_early", 64'(busy[0]), 64'h1);
        wait_done(0, "odd_done");
        check_log_size(0, 2, "odd_nwr");
        check_wr(0, 0, 23'h0, 16'hBBAA, 2'b11);
        check_wr(0, 1, 23'h2, 16'h00CC, 2'b01);
        chk("odd_cnt", 64'(byte_count[0]), 64'd3);

        // Wait retry: the first write is held and reissued unchanged.
        log0.delete();
        mem_wait[0] = 1'b1;
        rom_loading[0] = 1'b1;
        for (int i = 1; i <= 8; i++) send_byte(0, 8'(i));
        end_load(0);
        for (int k = 0; k < 3; k++) begin
            chk("retry_wr", 64'(mem_wr[0]), 64'h1);
            chk("retry_addr", 64'(mem_addr[0]), 64'h0);
            chk("retry_din", 64'(mem_din[0]), 64'h0201);
            tick();
        end
        check_log_size(0, 0, "retry_nolog");
        mem_wait[0] = 1'b0;
        wait_done(0, "retry_done");
        check_log_size(0, 4, "retry_nwr");
        check_wr(0, 0, 23'h0, 16'h0201, 2'b11);
        check_wr(0, 1, 23'h2, 16'h0403, 2'b11);
        check_wr(0, 2, 23'h4, 16'h0605, 2'b11);
        check_wr(0, 3, 23'h6, 16'h0807, 2'b11);

        // Restart mid-drain aborts the write and flushes queued words.
        log0.delete();
        mem_wait[0] = 1'b1;
        rom_loading[0] = 1'b1;
        for (int i = 1; i <= 4; i++) send_byte(0, 8'(i));
        end_load(0);
        tick();
        chk("rs_wr_before", 64'(mem_wr[0]), 64'h1);
        rom_loading[0] = 1'b1;
        tick();
        chk("rs_wr_abort", 64'(mem_wr[0]), 64'h0);
        chk("rs_cnt", 64'(byte_count[0]), 64'h0);
        chk("rs_busy", 64'(busy[0]), 64'h1);
        chk("rs_done", 64'(done[0]), 64'h0);
        mem_wait[0] = 1'b0;
        send_byte(0, 8'h55);
        send_byte(0, 8'h66);
        end_load(0);
        wait_done(0, "rs_done_end");
        check_log_size(0, 1, "rs_nwr");
        check_wr(0, 0, 23'h0, 16'h6655, 2'b11);

        // Overflow on depth 4: sixth word dropped, index still advances.
        log1.delete();
        mem_wait[1] = 1'b1;
        rom_loading[1] = 1'b1;
        for (int i = 0; i < 10; i++) send_byte(1, 8'(8'h10 + i));
        chk("ovf_before", 64'(overflow[1]), 64'h0);
        send_byte(1, 8'h1A);
        send_byte(1, 8'h1B);
        chk("ovf_set", 64'(overflow[1]), 64'h1);
        end_load(1);
        mem_wait[1] = 1'b0;
        wait_done(1, "ovf_done");
        check_log_size(1, 5, "ovf_nwr");
        check_wr(1, 0, 23'h7FFFFC, 16'h1110, 2'b11);
        check_wr(1, 1, 23'h7FFFFE, 16'h1312, 2'b11);
        check_wr(1, 2, 23'h000000, 16'h1514, 2'b11);
        check_wr(1, 3, 23'h000002, 16'h1716, 2'b11);
        check_wr(1, 4, 23'h000004, 16'h1918, 2'b11);
        chk("ovf_cnt", 64'(byte_count[1]), 64'd12);
        chk("ovf_sticky", 64'(overflow[1]), 64'h1);

        // Address wrap with no stalls; the start clears overflow.
        log1.delete();
        rom_loading[1] = 1'b1;
        for (int i = 1; i <= 8; i++) send_byte(1, 8'(8'h20 + i));
        end_load(1);
        wait_done(1, "wrap_done");
        chk("wrap_ovf", 64'(overflow[1]), 64'h0);
        check_log_size(1, 4, "wrap_nwr");
        check_wr(1, 0, 23'h7FFFFC, 16'h2221, 2'b11);
        check_wr(1, 1, 23'h7FFFFE, 16'h2423, 2'b11);
        check_wr(1, 2, 23'h000000, 16'h2625, 2'b11);
        check_wr(1, 3, 23'h000002, 16'h2827, 2'b11);

        // Reset mid-WAIT takes effect before the next clock edge.
        mem_wait[0] = 1'b1;
        rom_loading[0] = 1'b1;
        send_byte(0, 8'h77);
        send_byte(0, 8'h88);
        end_load(0);
        tick();
        chk("ar_wr_before", 64'(mem_wr[0]), 64'h1);
        chk("ar_din_before", 64'(mem_din[0]), 64'h8877);
        #2;
        reset = 1'b1;
        #1;
        chk("ar_wr", 64'(mem_wr[0]), 64'h0);
        chk("ar_addr", 64'(mem_addr[0]), 64'h0);
        chk("ar_din", 64'(mem_din[0]), 64'h0);
        chk("ar_ds", 64'(mem_ds[0]), 64'h0);
        chk("ar_busy", 64'(busy[0]), 64'h0);
        chk("ar_done", 64'(done[0]), 64'h0);
        chk("ar_cnt", 64'(byte_count[0]), 64'h0);
        chk("ar_done1", 64'(done[1]), 64'h0);
        chk("ar_addr1", 64'(mem_addr[1]), 64'h7FFFFC);
        tick();
        reset = 1'b0;
        tick();
        tick();
        chk("ar_fifo_flushed", 64'(mem_wr[0]), 64'h0);
        chk("ar_stay_idle", 64'(busy[0]), 64'h0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
